uart_tx_fifo: RTL and testbench

Byte-oriented UART transmitter with an internal write FIFO. It sits between a host-side byte producer and the serial TX pin. The host pushes bytes into the FIFO. When transmission is enabled, the block serialises each byte as an 8N1 frame (start, 8 data bits LSB first, stop), holding each bit for a programmable number of clock cycles.

---
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to add an even-parity bit
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_we_i,
  input  logic [7:0] din_i,
  input  logic       tx_en_i,
  output logic       tx_bit_o,
  output logic       empty_o,
  output logic       full_o,
  output logic       busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BMAX = CW'(BAUD_DIV - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q, par_d;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   fcnt_q;
  logic [CW-1:0] bc_q, bc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          push, pop, last;
  assign empty_o  = fcnt_q == '0;
  assign full_o   = fcnt_q == (AW+1)'(FIFO_DEPTH);
  assign busy_o   = state_q != IDLE;
  assign tx_bit_o = tx_q;
  assign push     = tx_we_i & ~full_o;
  assign pop      = (state_q == IDLE) & tx_en_i & ~empty_o;
  assign last     = bc_q == '0;
  // FIFO storage; contents are not reset, the cleared pointers make them invisible
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= din_i;
  end
  // FIFO pointers and occupancy, judged on the pre-edge count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      wr_q   <= wr_q + AW'(push);
      rd_q   <= rd_q + AW'(pop);
      fcnt_q <= fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // Frame state, baud counter, shift register and registered serial output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bc_q    <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  // Next-state logic; tx_d is the level the line takes after the coming edge
  always_comb begin
    state_d = state_q;
    bc_d    = last ? BMAX : bc_q - CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        bc_d = pop ? BMAX : '0;
        tx_d = ~pop;
        if (pop) begin
          state_d = START;
          sh_d    = mem_q[rd_q];
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem_q[rd_q];
`endif
        end
      end
      START: begin
        if (last) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (last) begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 3'd1;
          tx_d  = sh_q[1];
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (last) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with BAUD_DIV=4, FIFO_DEPTH=16
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst, tx_we, tx_en;
  logic [7:0] din;
  logic       tx_bit, empty, full, busy;
  int         n_chk = 0;
  int         n_fail = 0;
  uart_tx_fifo #(.BAUD_DIV(4), .FIFO_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .tx_we_i(tx_we), .din_i(din), .tx_en_i(tx_en),
    .tx_bit_o(tx_bit), .empty_o(empty), .full_o(full), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [7:0] b);
    tx_we = 1'b1;
    din   = b;
    step();
    tx_we = 1'b0;
  endtask
  // Checks one whole frame cycle by cycle, starting on its first start-bit cycle
  task automatic frame(input logic [7:0] b, input int drop);
    logic [10:0] bits;
    int nb;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
    nb = 11;
`else
    bits = {2'b11, b, 1'b0};
    nb = 10;
`endif
    for (int j = 0; j < nb; j++) begin
      for (int c = 0; c < 4; c++) begin
        if (j * 4 + c == drop) tx_en = 1'b0;
        chk($sformatf("byte%02h_bit%0d_cyc%0d", b, j, c), tx_bit, bits[j]);
        chk($sformatf("byte%02h_busy%0d", b, j), busy, 1'b1);
        step();
      end
    end
    chk($sformatf("byte%02h_idle_tx", b), tx_bit, 1'b1);
    chk($sformatf("byte%02h_idle_busy", b), busy, 1'b0);
  endtask
  initial begin
    rst = 1'b1; tx_we = 1'b0; tx_en = 1'b0; din = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_tx", tx_bit, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    // single byte
    wr(8'h41);
    chk("single_nonempty", empty, 1'b0);
    chk("single_noen_tx", tx_bit, 1'b1);
    tx_en = 1'b1;
    step();
    chk("single_start_tx", tx_bit, 1'b0);
    chk("single_empty_after_pop", empty, 1'b1);
    frame(8'h41, -1);
    tx_en = 1'b0;
    // stream of four bytes
    wr(8'h41); wr(8'h42); wr(8'h43); wr(8'h0A);
    chk("stream_nonempty", empty, 1'b0);
    tx_en = 1'b1;
    step();
    frame(8'h41, -1); step();
    frame(8'h42, -1); step();
    frame(8'h43, -1); step();
    frame(8'h0A, -1);
    chk("stream_end_empty", empty, 1'b1);
    chk("stream_end_busy", busy, 1'b0);
    tx_en = 1'b0;
    // overflow: 16 accepted, 17th dropped
    for (int i = 0; i < 16; i++) begin
      wr(8'h10 + 8'(i * 7));
      if (i == 14) chk("ovf_not_full_15", full, 1'b0);
      if (i == 15) chk("ovf_full_16", full, 1'b1);
    end
    wr(8'hEE);
    chk("ovf_full_17", full, 1'b1);
    tx_en = 1'b1;
    step();
    chk("ovf_not_full_after_pop", full, 1'b0);
    for (int i = 0; i < 16; i++) begin
      frame(8'h10 + 8'(i * 7), -1);
      if (i < 15) step();
    end
    chk("ovf_end_empty", empty, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ovf_no_17th_tx", tx_bit, 1'b1);
    end
    tx_en = 1'b0;
    // enable dropped during DATA of frame 1
    wr(8'hA5); wr(8'h3C);
    tx_en = 1'b1;
    step();
    frame(8'hA5, 10);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drop_no_restart_tx", tx_bit, 1'b1);
      chk("drop_no_restart_busy", busy, 1'b0);
    end
    chk("drop_nonempty", empty, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("drop_rst_empty", empty, 1'b1);
    // reset during the start bit
    wr(8'h55); wr(8'h66);
    tx_en = 1'b1;
    step();
    chk("midrst_start_tx", tx_bit, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx_bit, 1'b1);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("midrst_no_resume_tx", tx_bit, 1'b1);
      chk("midrst_no_resume_busy", busy, 1'b0);
    end
    tx_en = 1'b0;
    // simultaneous write and pop keeps the count
    wr(8'h81);
    tx_we = 1'b1;
    din   = 8'h7E;
    tx_en = 1'b1;
    step();
    tx_we = 1'b0;
    chk("simul_nonempty", empty, 1'b0);
    chk("simul_not_full", full, 1'b0);
    frame(8'h81, -1);
    step();
    frame(8'h7E, -1);
    chk("simul_end_empty", empty, 1'b1);
    tx_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
